// File: rtl/move_queue_pkg.sv
// Shared game definitions: direction codes from the debouncer and the move queue depth default.
package game_pkg;

  typedef logic [1:0] dir_t;
  typedef logic [2:0] dir_code_t;

  localparam dir_code_t DIR_UP    = 3'd0;
  localparam dir_code_t DIR_DOWN  = 3'd1;
  localparam dir_code_t DIR_LEFT  = 3'd2;
  localparam dir_code_t DIR_RIGHT = 3'd3;
  localparam dir_code_t DIR_NONE  = 3'd4;

  localparam int MQ_DEPTH_DEFAULT = 4;

  // Codes 4..7 all mean "no move", so only the top bit matters.
  function automatic logic isMove(input dir_code_t code);
    return !code[2];
  endfunction

endpackage

// File: rtl/move_queue_if.sv
// Handshake bundle between debouncer/engine (master side) and move_queue (slave side).
// Optional drop_cnt signal present only when MOVE_QUEUE_DROP_CNT_EN is defined.
interface move_queue_if
  import game_pkg::*;
#(
  parameter int DEPTH = MQ_DEPTH_DEFAULT
);
  localparam int CW = $clog2(DEPTH + 1);

  dir_code_t       dir_in;
  logic            flush;
  logic            move_valid;
  dir_t            move_dir;
  logic            move_ready;
  logic [CW-1:0]   count;
  logic            full;
  logic            empty;
  logic            overflow;
`ifdef MOVE_QUEUE_DROP_CNT_EN
  logic [7:0]      drop_cnt;
`endif

  modport master (
    output dir_in, flush, move_ready,
`ifdef MOVE_QUEUE_DROP_CNT_EN
    input  drop_cnt,
`endif
    input  move_valid, move_dir, count, full, empty, overflow
  );

  modport slave (
    input  dir_in, flush, move_ready,
`ifdef MOVE_QUEUE_DROP_CNT_EN
    output drop_cnt,
`endif
    output move_valid, move_dir, count, full, empty, overflow
  );

endinterface

// File: rtl/move_queue_mem.sv
// DEPTH x 2 move storage: one synchronous write port, one asynchronous read port, no reset.
module move_queue_mem
  import game_pkg::*;
#(
  parameter int DEPTH = MQ_DEPTH_DEFAULT,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  dir_t          i_wdata,
  input  logic [AW-1:0] i_raddr,
  output dir_t          o_rdata
);

  dir_t r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/move_queue.sv
// Move FIFO between debouncer and board engine; pointer/count control around move_queue_mem.
// Define MOVE_QUEUE_DROP_CNT_EN to add the saturating drop_cnt output.
module move_queue
  import game_pkg::*;
#(
  parameter int DEPTH = MQ_DEPTH_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  move_queue_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [AW-1:0] r_wrPtr;
  logic [AW-1:0] r_rdPtr;
  logic [CW-1:0] r_count;
  logic          r_full;
  logic          r_empty;
  logic          r_overflow;

  logic          w_push;
  logic          w_pop;
  logic          w_accept;
  logic          w_drop;
  logic          w_we;
  logic [CW-1:0] w_countNext;
  dir_t          w_rdData;

  assign w_push   = isMove(bus.dir_in);
  assign w_pop    = !r_empty && bus.move_ready;
  // A push into a full queue still fits when the head leaves in the same cycle.
  assign w_accept = w_push && (!r_full || w_pop);
  assign w_drop   = w_push && r_full && !w_pop;
  assign w_we     = w_accept && !rst && !bus.flush;

  assign w_countNext = r_count + CW'(w_accept) - CW'(w_pop);

  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      r_wrPtr    <= '0;
      r_rdPtr    <= '0;
      r_count    <= '0;
      r_full     <= 1'b0;
      r_empty    <= 1'b1;
      r_overflow <= 1'b0;
    end else begin
      if (w_accept) begin
        r_wrPtr <= r_wrPtr + AW'(1);
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + AW'(1);
      end
      r_count    <= w_countNext;
      r_full     <= (w_countNext == CW'(DEPTH));
      r_empty    <= (w_countNext == '0);
      r_overflow <= w_drop;
    end
  end

`ifdef MOVE_QUEUE_DROP_CNT_EN
  logic [7:0] r_dropCnt;

  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      r_dropCnt <= '0;
    end else if (w_drop && (r_dropCnt != 8'hFF)) begin
      r_dropCnt <= r_dropCnt + 8'd1;
    end
  end

  assign bus.drop_cnt = r_dropCnt;
`endif

  move_queue_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (r_wrPtr),
    .i_wdata (bus.dir_in[1:0]),
    .i_raddr (r_rdPtr),
    .o_rdata (w_rdData)
  );

  // Storage is never reset, so the head is masked to zero while nothing is queued.
  assign bus.move_valid = !r_empty;
  assign bus.move_dir   = r_empty ? 2'd0 : w_rdData;
  assign bus.count      = r_count;
  assign bus.full       = r_full;
  assign bus.empty      = r_empty;
  assign bus.overflow   = r_overflow;

endmodule

// File: doc/move_queue.md
# move_queue

Buffers single-cycle direction pulses from the debouncer and hands them one at a time to the game-board update engine over a valid/ready handshake. Board updates take many cycles, so this queue stops moves from being lost when the player presses buttons faster than the engine retires moves. It sits directly downstream of the debouncer and upstream of the board engine.

## Interface
- DEPTH, 4, number of queued moves; must be a power of two and ≥ 2.
- CW, $clog2(DEPTH+1), width of the occupancy count (derived, not overridden).

- clk  in  1  system clock, all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- dir_in  in  3  debouncer output. Codes 0–3 are a move pulse for one cycle; codes 4–7 mean no move.
- flush  in  1  one-cycle request to discard all queued moves, for example on game over or new game.
- move_valid  out  1  head entry is available.
- move_dir  out  2  direction of the head entry; valid only while move_valid is high.
- move_ready  in  1  the engine accepts the head entry when move_valid and move_ready are both high.
- count  out  CW  number of entries currently held.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- overflow  out  1  one-cycle pulse when a move is dropped because the queue is full.

## Operation
- A push occurs when dir_in < 4. The value dir_in[1:0] is written at wr_ptr.
- A pop occurs when move_valid and move_ready are both high. rd_ptr advances.
- Pointers are log2(DEPTH) bits wide and wrap naturally. Full and empty are decided from count, not from the pointers.
- Storage is a DEPTH×2 register array. move_dir = mem[rd_ptr], registered read-free from the array.
- Push while full and no pop in the same cycle:
  - the move is dropped;
  - overflow = 1 on the next cycle;
  - memory, pointers and count are unchanged.
- Push and pop in the same cycle while full: both succeed, count stays at DEPTH, overflow = 0.
- Push and pop in the same cycle while neither empty nor full: both succeed, count is unchanged.
- Push while empty: there is no bypass. move_valid rises the cycle after the push.
- flush:
  - wr_ptr, rd_ptr and count go to 0, and overflow goes to 0;
  - flush overrides any push or pop in the same cycle, and that push is discarded;
  - memory contents are left as they are.
- move_valid = !empty. move_dir must hold stable while move_valid is high and move_ready is low.
- Reset values: move_valid = 0, move_dir = 0, count = 0, full = 0, empty = 1, overflow = 0, pointers = 0. Memory does not need a reset.
- Reset asserted mid-operation has the same effect as flush, and rst has priority over flush.

## Timing
- Latency from push to move_valid is 1 cycle.
- Pop takes effect on the accepting edge. The next entry appears in the same cycle the pointer updates, so back-to-back pops sustain 1 move per cycle.
- count, full, empty and overflow are registered and update on the clock edge following the event.
- move_ready may be held high permanently. It may also fall while move_valid is high; no entry is consumed in that case.

## Configuration
- Macro: MOVE_QUEUE_DROP_CNT_EN.
- Defined:
  - adds output drop_cnt, out, 8 bits: a saturating count of dropped moves, held at 255 once it reaches 255;
  - cleared by rst and by flush;
  - increments in the same cycle that overflow is set.
- Undefined: the port and its counter are absent. overflow behaviour is identical in both builds.

## Structure
- Shared package game_pkg holds:
  - direction constants DIR_UP = 0, DIR_DOWN = 1, DIR_LEFT = 2, DIR_RIGHT = 3, DIR_NONE = 4;
  - typedef dir_t (2-bit move) and typedef dir_code_t (3-bit debouncer code);
  - the default for DEPTH.
- One sub-module, move_queue_mem: DEPTH×2 storage with a write port and an asynchronous read port. Pointer and count control stays in move_queue.

## Test plan
- Reset then idle with dir_in = 4: empty = 1, move_valid = 0, count = 0 for 20 cycles.
- Push 1, 3, 0, 2 on separate cycles with move_ready = 0, then hold move_ready = 1:
  - move_dir reads 1, 3, 0, 2 on consecutive cycles;
  - count steps 4 → 0;
  - empty rises after the last pop.
- Fill to 4 entries, then push 2 with move_ready = 0:
  - overflow pulses for 1 cycle;
  - count stays 4;
  - draining returns the original 4 entries.
  - With MOVE_QUEUE_DROP_CNT_EN defined, drop_cnt = 1.
- Full queue, push 3 and pop in the same cycle: count stays 4, overflow = 0, and the last entry drained is 3.
- Queue holds 2 entries; assert flush together with a push of 1: next cycle count = 0 and empty = 1, and the pushed move never appears.
- Pointer wrap: run 10 push/pop pairs in sequence 0, 1, 2, 3, … Output order matches input order across the wrap, and count never exceeds 1.
